// File: rtl/mod_slot_arbiter.sv
// -----------------------------------------------------------------------------
// mod_slot_arbiter
//   Round-robin arbiter sharing one resource among NUM_REQ requesters.
//   A mod-NUM_REQ rotation pointer (slot) names the highest-priority requester
//   for the next arbitration. An owner keeps the grant until it drops its
//   request or until it has held the grant for HOLD_MAX cycles, at which point
//   the grant is forcibly released and preempt pulses for one cycle. Every
//   release is followed by exactly one idle cycle (bus-turnaround bubble).
//
// Ports
//   clk      in   1        rising-edge clock
//   rst      in   1        asynchronous, active-high reset
//   en       in   1        1 = new grants allowed (a grant in progress always completes)
//   req      in   NUM_REQ  level request per requester
//   gnt      out  NUM_REQ  registered one-hot grant, zero when no owner
//   gnt_id   out  ID_W     index of current owner, holds last value when idle
//   busy     out  1        high while a grant is active (|gnt)
//   slot     out  ID_W     rotation pointer for the next arbitration
//   preempt  out  1        one-cycle pulse after a HOLD_MAX forced release
// -----------------------------------------------------------------------------
module mod_slot_arbiter #(
  parameter int NUM_REQ  = 5,
  parameter int HOLD_MAX = 4,
  parameter int ID_W     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               busy,
  output logic [ID_W-1:0]    slot,
  output logic               preempt
);

  localparam int HC_W = $clog2(HOLD_MAX + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [ID_W-1:0]    gnt_id_d;
  logic [ID_W-1:0]    slot_d;
  logic               preempt_d;
  logic [HC_W-1:0]    hold_q, hold_d;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [ID_W-1:0]      win_id;
  logic                 owner_req;
  logic                 hold_max_hit;

  // Increment modulo NUM_REQ by compare-and-wrap; NUM_REQ need not be a
  // power of two, so natural counter overflow cannot be relied on.
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
    if (v == ID_W'(NUM_REQ - 1)) begin
      return '0;
    end
    return v + 1'b1;
  endfunction

  // Rotate req so that bit 0 is the requester at slot; the first set bit of
  // the rotated vector is then the round-robin winner, offset from slot.
  assign req_dbl = {req, req} >> slot;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  always_comb begin : find_winner
    logic [NUM_REQ-1:0] scan;
    logic               hit;
    int                 pos;
    scan   = req_rot;
    hit    = 1'b0;
    pos    = 0;
    win_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!hit && scan[0]) begin
        hit = 1'b1;
        pos = int'(slot) + k;
        if (pos >= NUM_REQ) begin
          pos = pos - NUM_REQ;
        end
        win_id = ID_W'(pos);
      end
      scan = scan >> 1;
    end
  end

  // gnt is one-hot on the owner, so masking avoids a variable-width index.
  assign owner_req    = |(req & gnt);
  assign hold_max_hit = (hold_q == HC_W'(HOLD_MAX));
  assign busy         = |gnt;

  always_comb begin : next_state
    state_d   = state_q;
    gnt_d     = gnt;
    gnt_id_d  = gnt_id;
    slot_d    = slot;
    preempt_d = 1'b0;
    hold_d    = hold_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (en && (|req)) begin
          gnt_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
          gnt_id_d = win_id;
          hold_d   = HC_W'(1);
          state_d  = GRANT;
        end
      end
      GRANT: begin
        // A dropped request wins over the hold limit, so a simultaneous
        // drop at HOLD_MAX counts as voluntary and does not preempt.
        if (!owner_req || hold_max_hit) begin
          gnt_d     = '0;
          slot_d    = wrap_inc(gnt_id);
          state_d   = IDLE;
          preempt_d = owner_req;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Register stage: all control and grant state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      slot    <= '0;
      preempt <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      gnt_id  <= gnt_id_d;
      slot    <= slot_d;
      preempt <= preempt_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_mod_slot_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mod_slot_arbiter
//   Directed and randomized stimulus for mod_slot_arbiter, compared each cycle
//   against a behavioural model of the round-robin rules.
// -----------------------------------------------------------------------------
module tb_mod_slot_arbiter;

  localparam int N    = 5;
  localparam int HOLD = 4;
  localparam int IW   = 3;

  logic          clk;
  logic          rst;
  logic          en;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          busy;
  logic [IW-1:0] slot;
  logic          preempt;

  int n_vec;
  int n_err;

  // Behavioural model state
  bit m_busy;
  int m_owner;
  int m_hold;
  int m_slot;
  bit m_pre;
  bit prev_pre;

  mod_slot_arbiter #(
    .NUM_REQ (N),
    .HOLD_MAX(HOLD),
    .ID_W    (IW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy),
    .slot   (slot),
    .preempt(preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit req_bit(input logic [N-1:0] r, input int i);
    logic [N-1:0] t;
    t = r >> i;
    return t[0];
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_hold  = 0;
    m_slot  = 0;
    m_pre   = 1'b0;
  endtask

  // One clock of the arbitration rules, using the inputs seen at the edge.
  task automatic model_update();
    if (!m_busy) begin
      m_pre = 1'b0;
      if (en && (req != '0)) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_slot + k) % N;
          if (req_bit(req, i)) begin
            m_owner = i;
            m_hold  = 1;
            m_busy  = 1'b1;
            break;
          end
        end
      end
    end else begin
      if (!req_bit(req, m_owner)) begin
        m_busy = 1'b0;
        m_slot = (m_owner + 1) % N;
        m_pre  = 1'b0;
      end else if (m_hold == HOLD) begin
        m_busy = 1'b0;
        m_slot = (m_owner + 1) % N;
        m_pre  = 1'b1;
      end else begin
        m_hold = m_hold + 1;
        m_pre  = 1'b0;
      end
    end
  endtask

  task automatic check(input string tag);
    logic [N-1:0]  eg;
    logic [IW-1:0] eid;
    logic [IW-1:0] esl;
    eg  = m_busy ? (N'(1) << m_owner) : '0;
    eid = IW'(m_owner);
    esl = IW'(m_slot);
    n_vec++;
    assert (gnt === eg) else begin
      n_err++;
      $error("FAIL %s gnt got %b want %b", tag, gnt, eg);
    end
    assert (gnt_id === eid) else begin
      n_err++;
      $error("FAIL %s gnt_id got %0d want %0d", tag, gnt_id, eid);
    end
    assert (busy === m_busy) else begin
      n_err++;
      $error("FAIL %s busy got %b want %b", tag, busy, m_busy);
    end
    assert (slot === esl) else begin
      n_err++;
      $error("FAIL %s slot got %0d want %0d", tag, slot, esl);
    end
    assert (preempt === m_pre) else begin
      n_err++;
      $error("FAIL %s preempt got %b want %b", tag, preempt, m_pre);
    end
    assert (!(preempt === 1'b1 && prev_pre)) else begin
      n_err++;
      $error("FAIL %s preempt_twice got %b want 0", tag, preempt);
    end
    prev_pre = (preempt === 1'b1);
  endtask

  // Advance one clock, update the model, then compare 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      model_update();
    end
    #1;
    check(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step("reset");
    rst = 1'b0;
  endtask

  initial begin
    int pre_cnt;
    n_vec    = 0;
    n_err    = 0;
    prev_pre = 1'b0;
    model_reset();

    // Reset asserted asynchronously with random requests, before any edge
    rst = 1'b0;
    en  = 1'b1;
    req = N'($urandom);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset");
    step("reset_hold");
    step("reset_hold");
    rst = 1'b0;
    req = '0;
    step("idle_after_reset");

    // Single requester 2 for two cycles, then release -> slot 3
    req = 5'b00100;
    step("single_grant");
    step("single_hold");
    req = '0;
    step("single_release");
    step("single_idle");

    // slot=3 with requesters 4 and 0: 4 first, then 0, slot ends at 1
    req = 5'b10001;
    step("rr_grant4");
    step("rr_hold4");
    req = 5'b00001;
    step("rr_release4");
    step("rr_grant0");
    req = '0;
    step("rr_release0");
    step("rr_idle");

    // Sustained all-request load from slot 0
    do_reset();
    req     = 5'b11111;
    pre_cnt = 0;
    for (int c = 0; c < 26; c++) begin
      step("all_req");
      if (preempt === 1'b1) pre_cnt++;
    end
    n_vec++;
    assert (pre_cnt == 5) else begin
      n_err++;
      $error("FAIL all_req_preempt_count got %0d want 5", pre_cnt);
    end
    req = '0;
    step("all_req_drop");
    step("all_req_idle");

    // Reset on the second cycle of a grant to requester 2
    req = 5'b00100;
    step("rst_grant_c1");
    step("rst_grant_c2");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_mid_grant");
    step("rst_mid_hold");
    rst = 1'b0;
    req = 5'b00101;
    step("post_rst_grant0");
    req = '0;
    step("post_rst_release");
    step("post_rst_idle");

    // en gating: no new grants while en=0, an active grant completes
    en  = 1'b0;
    req = 5'b01000;
    for (int c = 0; c < 3; c++) step("en_low_idle");
    en = 1'b1;
    step("en_grant3");
    en = 1'b0;
    for (int c = 0; c < 7; c++) step("en_drop_mid_grant");
    en = 1'b1;
    step("en_regrant");
    req = '0;
    step("en_release");
    step("en_idle");

    // Randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 99) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("rand_async_rst");
        step("rand_rst_hold");
        rst = 1'b0;
      end else begin
        step("random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
